harness_checksum_sink: RTL and testbench



---
 rtl/harness_pkg.sv | 18 +
 rtl/vector_xor.sv | 11 +
 rtl/harness_checksum_sink.sv | 85 ++++++++
 tb/tb_harness_checksum_sink.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harness_pkg.sv
// Shared types and helpers for the checksum sink harness.
package harness_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int lane_width(input int data_width, input int lanes);
        return data_width / lanes;
    endfunction

    function automatic bit cfg_ok(input int data_width, input int lanes);
        return (lanes >= 2) && (data_width % lanes == 0);
    endfunction

endpackage

// File: rtl/vector_xor.sv
// Reduces one lane of a data word to its parity bit.
module vector_xor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    assign parity = ^data;

endmodule

// File: rtl/harness_checksum_sink.sv
// AXI-stream sink: folds accepted beats into a lane-parity signature
// and counts run and stall cycles for a programmed beat count.
module harness_checksum_sink
    import harness_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int LANES       = 8,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] num_beats,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    output logic                   busy,
    output logic                   done,
    output logic [LANES-1:0]       checksum,
    output logic [COUNT_WIDTH-1:0] cycles,
    output logic [COUNT_WIDTH-1:0] stall_cycles
);

    localparam int LW = lane_width(DATA_WIDTH, LANES);

    if (!cfg_ok(DATA_WIDTH, LANES)) begin : g_cfg_err
        $error("harness_checksum_sink: bad DATA_WIDTH/LANES");
    end

    state_t                 state;
    logic [COUNT_WIDTH-1:0] beats_left;
    logic [LANES-1:0]       lane_par;
    logic                   handshake;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        vector_xor #(.WIDTH(LW)) u_xor (
            .data   (s_axis_tdata[i*LW +: LW]),
            .parity (lane_par[i])
        );
    end

    assign s_axis_tready = (state == RUN);
    assign busy          = (state == RUN);
    assign done          = (state == DONE);
    assign handshake     = s_axis_tvalid & s_axis_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            beats_left   <= '0;
            checksum     <= '0;
            cycles       <= '0;
            stall_cycles <= '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        beats_left   <= num_beats;
                        checksum     <= '0;
                        cycles       <= '0;
                        stall_cycles <= '0;
                        state        <= (num_beats == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    cycles <= cycles + 1'b1;
                    if (!s_axis_tvalid) begin
                        stall_cycles <= stall_cycles + 1'b1;
                    end
                    if (handshake) begin
                        checksum   <= {checksum[LANES-2:0], checksum[LANES-1]}
                                      ^ lane_par;
                        beats_left <= beats_left - 1'b1;
                        // leave RUN on the last decrement so beats_left never underflows
                        if (beats_left == 1) begin
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_harness_checksum_sink.sv
// Randomized and directed bench for harness_checksum_sink against
// an arithmetic model of the lane-parity signature.
module tb_harness_checksum_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] num_beats;
    logic [63:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;
    logic [31:0] cycles;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    harness_checksum_sink #(
        .DATA_WIDTH  (64),
        .LANES       (8),
        .COUNT_WIDTH (32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .num_beats     (num_beats),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .busy          (busy),
        .done          (done),
        .checksum      (checksum),
        .cycles        (cycles),
        .stall_cycles  (stall_cycles)
    );

    // Signature of a beat sequence: each lane bit is the odd-parity of its byte,
    // folded into a running value that is rotated left by one per beat.
    function automatic int model_sig(input logic [63:0] beats[$]);
        int sig = 0;
        foreach (beats[k]) begin
            int par = 0;
            for (int l = 0; l < 8; l++) begin
                if ($countones(beats[k][l*8 +: 8]) % 2 == 1) par += (1 << l);
            end
            sig = (((sig * 2) % 256) + (sig / 128)) ^ par;
        end
        return sig;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; num_beats = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        tick(); tick();
        n_checks++;
        if ({s_axis_tready, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 000", {s_axis_tready, busy, done});
        end
        n_checks++;
        if ({checksum, cycles, stall_cycles} !== '0) begin
            n_fail++;
            $display("FAIL reset_results got %h/%0d/%0d want 0", checksum, cycles, stall_cycles);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if ({s_axis_tready, busy, done} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset got %b want 000", {s_axis_tready, busy, done});
        end
    endtask

    task automatic test_back_to_back();
        start = 1'b1; num_beats = 2;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, s_axis_tready, done} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_start got %b want 110", {busy, s_axis_tready, done});
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h1;
        tick();
        n_checks++;
        if (checksum !== 8'h01 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_beat1 got %h done=%b want 01 done=0", checksum, done);
        end
        tick();
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (checksum !== 8'h03 || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_beat2 got %h done=%b want 03 done=1", checksum, done);
        end
        n_checks++;
        if (cycles !== 32'd2 || stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL b2b_counts got %0d/%0d want 2/0", cycles, stall_cycles);
        end
    endtask

    task automatic test_stalled();
        logic [63:0] data [3] = '{64'h3, 64'h100, 64'hFF};
        logic [7:0]  exp  [3] = '{8'h00, 8'h02, 8'h04};
        start = 1'b1; num_beats = 3;
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            s_axis_tvalid = 1'b0;
            tick();
            s_axis_tvalid = 1'b1; s_axis_tdata = data[k];
            tick();
            n_checks++;
            if (checksum !== exp[k]) begin
                n_fail++;
                $display("FAIL stall_beat%0d got %h want %h", k, checksum, exp[k]);
            end
        end
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || cycles !== 32'd6 || stall_cycles !== 32'd3) begin
            n_fail++;
            $display("FAIL stall_final got done=%b %0d/%0d want 1 6/3", done, cycles, stall_cycles);
        end
    endtask

    task automatic test_zero();
        bit ready_seen = 0;
        start = 1'b1; num_beats = 0; s_axis_tvalid = 1'b1; s_axis_tdata = 64'hFF;
        tick();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || checksum !== 8'h00 || cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL zero_done got done=%b %h %0d want 1 00 0", done, checksum, cycles);
        end
        for (int k = 0; k < 4; k++) begin
            if (s_axis_tready) ready_seen = 1;
            tick();
        end
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (ready_seen || checksum !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_ready got ready=%b chk=%h want 0 00", ready_seen, checksum);
        end
    endtask

    task automatic test_restart();
        start = 1'b1; num_beats = 4;
        tick();
        start = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h1;
        tick();
        s_axis_tvalid = 1'b0; start = 1'b1; num_beats = 9;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || cycles !== 32'd2 || stall_cycles !== 32'd1 || checksum !== 8'h01) begin
            n_fail++;
            $display("FAIL run_start_ignored got busy=%b %0d/%0d %h want 1 2/1 01",
                     busy, cycles, stall_cycles, checksum);
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h0;
        tick(); tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL run_early_done got %b want 0", done);
        end
        tick();
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || cycles !== 32'd5 || checksum !== 8'h08) begin
            n_fail++;
            $display("FAIL run_four_done got done=%b %0d %h want 1 5 08", done, cycles, checksum);
        end
        start = 1'b1; num_beats = 1;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || checksum !== 8'h00 || cycles !== 32'd0 || stall_cycles !== 32'd0) begin
            n_fail++;
            $display("FAIL restart_clear got busy=%b %h %0d/%0d want 1 00 0/0",
                     busy, checksum, cycles, stall_cycles);
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h80;
        tick();
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || checksum !== 8'h01) begin
            n_fail++;
            $display("FAIL restart_result got done=%b %h want 1 01", done, checksum);
        end
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1; num_beats = 4;
        tick();
        start = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'hFFFF_0000_1234_0001;
        tick();
        s_axis_tvalid = 1'b0; rst = 1'b1; start = 1'b1; num_beats = 2;
        tick();
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if ({s_axis_tready, busy, done} !== 3'b000 || {checksum, cycles, stall_cycles} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset got %b %h %0d %0d want 000 0", {s_axis_tready, busy, done},
                     checksum, cycles, stall_cycles);
        end
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_beats_start got busy=%b want 0", busy);
        end
        start = 1'b1; num_beats = 1;
        tick();
        start = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 64'h1;
        tick();
        s_axis_tvalid = 1'b0;
        n_checks++;
        if (done !== 1'b1 || checksum !== 8'h01 || cycles !== 32'd1) begin
            n_fail++;
            $display("FAIL post_reset_run got done=%b %h %0d want 1 01 1", done, checksum, cycles);
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            logic [63:0] accepted[$];
            int n      = $urandom_range(1, 12);
            int left   = n;
            int exp_c  = 0;
            int exp_s  = 0;
            int budget = 0;
            start = 1'b1; num_beats = n;
            tick();
            start = 1'b0;
            while (left > 0 && budget < 200) begin
                s_axis_tvalid = ($urandom_range(0, 3) != 0);
                s_axis_tdata  = {$urandom, $urandom};
                exp_c++;
                if (s_axis_tvalid) begin
                    accepted.push_back(s_axis_tdata);
                    left--;
                end else begin
                    exp_s++;
                end
                budget++;
                tick();
            end
            s_axis_tvalid = 1'b0;
            n_checks++;
            if (left != 0 || done !== 1'b1) begin
                n_fail++;
                $display("FAIL rand%0d_done got done=%b left=%0d want 1 0", r, done, left);
            end
            n_checks++;
            if (checksum !== 8'(model_sig(accepted))) begin
                n_fail++;
                $display("FAIL rand%0d_sig got %h want %h", r, checksum, 8'(model_sig(accepted)));
            end
            n_checks++;
            if (cycles !== 32'(exp_c) || stall_cycles !== 32'(exp_s)) begin
                n_fail++;
                $display("FAIL rand%0d_counts got %0d/%0d want %0d/%0d", r,
                         cycles, stall_cycles, exp_c, exp_s);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_beats = '0;
        s_axis_tdata = '0; s_axis_tvalid = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_stalled();
        test_zero();
        test_restart();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
